// File: rtl/nibble_tx_pkg.sv
// nibble_tx_pkg
// Shared definitions for the nibble_tx serial transmitter:
//   state_t      - frame sequencer states
//   PARITY_*     - values accepted by the PARITY parameter
//   min1_clog2   - $clog2 clamped to at least 1 bit, used to size counters
package nibble_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  // A counter that only ever holds 0 still needs one bit of storage.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_tx_bit_timer.sv
// nibble_tx_bit_timer
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; held at 0 while
// clear is high.
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   clear      in  force the count to 0 on the next edge
//   tick       out count is at its terminal value this cycle
//   tick_next  out count will be at its terminal value next cycle
module nibble_tx_bit_timer
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int TW = min1_clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear || count_reg == LAST) begin
      count_next = '0;
    end else begin
      count_next = count_reg + TW'(1);
    end
  end

  assign tick      = (count_reg == LAST);
  // Look-ahead lets the owner drive registered outputs that line up with
  // the final cycle of a bit.
  assign tick_next = (count_next == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/nibble_tx.sv
// nibble_tx
// Framed LSB-first serial transmitter: start bit (0), WIDTH data bits,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
//   clk         in  system clock
//   reset       in  synchronous active-high reset
//   d           in  parallel word, captured when load is accepted
//   load        in  request to transmit d (accepted only while ready)
//   ready       out block is idle and will accept load
//   tx          out serial line (registered, idles high)
//   busy        out frame in progress (registered)
//   frame_done  out one-cycle pulse in the last cycle of the stop bit
module nibble_tx
  import nibble_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int IW = min1_clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             parity_reg, parity_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic             frame_done_reg, frame_done_next;
  logic             tick, tick_next;

  // Timer is parked at 0 in IDLE so the first START cycle is count 0.
  nibble_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg == IDLE),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    idx_next    = idx_reg;
    parity_next = parity_reg;

    case (state_reg)
      IDLE: begin
        if (load) begin
          shift_next  = d;
          parity_next = ^d;
          idx_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = (PARITY == PARITY_EVEN) ? PAR : STOP;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      PAR: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the *next* state so they change on the
    // same edge as the state they describe.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PAR:     tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next       = (state_next != IDLE);
    frame_done_next = (state_next == STOP) && tick_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      idx_reg        <= '0;
      parity_reg     <= 1'b0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      idx_reg        <= idx_next;
      parity_reg     <= parity_next;
      tx_reg         <= tx_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign ready      = (state_reg == IDLE);
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/nibble_tx.md
# nibble_tx

Serial transmitter that consumes the 4-bit parallel word held in the synchronously-reset data register and shifts it out as a framed, LSB-first bit stream on a single line. Sits directly downstream of the register stage. Accepts a word via a load/ready handshake, emits start bit, data bits, optional even-parity bit and stop bit, then returns to idle.

## Interface
- WIDTH, 4, data word width (≥1)
- CLKS_PER_BIT, 4, clock cycles per serial bit (≥1)
- PARITY, 0, 0 = no parity bit, 1 = even-parity bit after data
- clk  input  1  single system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- d  input  WIDTH  parallel word from the upstream register output
- load  input  1  request to transmit d
- ready  output  1  high when block can accept a load (state IDLE)
- tx  output  1  serial line, idles high
- busy  output  1  high while a frame is in progress (not IDLE)
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit

## Operation
- Decided interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values (cycle after a reset edge): state IDLE, tx=1, busy=0, ready=1, frame_done=0, shift register 0, bit timer 0, bit index 0.
- States: IDLE → START → DATA → (PARITY if PARITY=1) → STOP → IDLE.
- IDLE: tx=1. On edge with load=1 (ready=1): capture d into shift register, compute even parity (XOR of d), go START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0]; after each CLKS_PER_BIT cycles shift right, index+1; after WIDTH bits go PARITY or STOP.
- PARITY: tx = XOR of captured word, CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in final cycle; then IDLE.
- Registered outputs: tx, busy, frame_done are flop outputs; ready = (state==IDLE).
- load while busy: ignored, no effect on current frame; d may change freely after capture.
- reset and load on same edge: reset wins, no frame starts.
- reset mid-frame: next cycle all outputs at reset values; partial frame abandoned, no frame_done.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT) (min 1). Bit index width $clog2(WIDTH) (min 1).

## Timing
- Load accepted at edge k → tx=0 from cycle k+1.
- Data bit i driven during cycles k+1+(1+i)·C … k+(2+i)·C, C=CLKS_PER_BIT.
- Frame length F = (WIDTH+2+PARITY)·C cycles; frame_done in cycle k+F; ready=1 from cycle k+F+1.
- Minimum load-to-load period F+1 cycles (at least one IDLE cycle between frames).
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no special casing beyond timer width.

## Structure
- nibble_tx_pkg: state enum typedef (IDLE, START, DATA, PAR, STOP), parity mode constants.
- One sub-module: bit_timer (counter with clear, emits tick on terminal count, synchronous active-high reset).
- Shift register, index counter and FSM live in nibble_tx.

## Test plan
- Reset then idle 10 cycles, load=0 → tx=1, busy=0, ready=1, frame_done=0 throughout.
- C=1, PARITY=0, load d=4'b1011 at edge k → tx sequence from k+1: 0,1,1,0,1,1; frame_done at k+6; ready at k+7.
- C=4, PARITY=1, d=4'b0111 → each bit held 4 cycles; parity bit=1; frame 28 cycles; frame_done in cycle k+28.
- Load held high continuously with d alternating 4'b0000/4'b1111 → frames back-to-back with exactly one idle cycle between; load during busy ignored.
- reset=1 mid DATA bit 2 → next cycle tx=1, busy=0, ready=1; no frame_done; next load starts fresh frame.
- reset=1 and load=1 same edge with d=4'b1111 → stays IDLE, tx=1, no frame emitted.
